// File: rtl/bomb_scheduler.sv
// Bomb scheduler: holds up to NUM_SLOTS armed bombs, counts their fuses down on tick,
// and launches at most one explosion at a time, with chain detonation along the blast cross.
module bomb_scheduler #(
    parameter int NUM_SLOTS   = 4,
    parameter int FUSE_TICKS  = 120,
    parameter int BLAST_TICKS = 40,
    parameter int TILE        = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 place,
    input  logic [9:0]           b_x,
    input  logic [9:0]           b_y,
    output logic                 explosion_write_enable,
    output logic [9:0]           exploding_bomb_x,
    output logic [9:0]           exploding_bomb_y,
    output logic [NUM_SLOTS-1:0] slot_valid,
    output logic [2:0]           active_count,
    output logic                 blast_active,
    output logic                 place_reject,
    output logic [1:0]           fsm_state
);

    localparam int         IDXW  = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [9:0] HALF  = 10'(TILE / 2);
    localparam logic [9:0] MASK  = ~10'(TILE - 1);
    localparam logic [10:0] REACH = 11'(3 * TILE);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_BLAST  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 place_q;
    logic                 reject_q, reject_d;
    logic [NUM_SLOTS-1:0] valid_q, valid_d;
    logic [7:0]           fuse_q [NUM_SLOTS];
    logic [7:0]           fuse_d [NUM_SLOTS];
    logic [9:0]           x_q    [NUM_SLOTS];
    logic [9:0]           x_d    [NUM_SLOTS];
    logic [9:0]           y_q    [NUM_SLOTS];
    logic [9:0]           y_d    [NUM_SLOTS];
    logic [7:0]           blast_cnt_q, blast_cnt_d;
    logic [9:0]           ex_q, ex_d, ey_q, ey_d;

    logic [9:0]           snap_x, snap_y;
    logic                 place_edge, dup_hit, free_any, accept;
    logic [IDXW-1:0]      free_idx;
    logic                 ripe_any;
    logic [IDXW-1:0]      ripe_idx;
    logic                 launch_en;
    logic [NUM_SLOTS-1:0] in_cross;
    logic [2:0]           count;

    function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // Snap to the nearest tile origin; the +HALF may wrap in 10 bits by design.
    assign snap_x     = (b_x + HALF) & MASK;
    assign snap_y     = (b_y + HALF) & MASK;
    assign place_edge = place & ~place_q;

    always_comb begin
        dup_hit  = 1'b0;
        free_any = 1'b0;
        free_idx = '0;
        ripe_any = 1'b0;
        ripe_idx = '0;
        in_cross = '0;
        count    = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_any = 1'b1;
                free_idx = IDXW'(i);
            end
            if (valid_q[i] && fuse_q[i] == 8'd0) begin
                ripe_any = 1'b1;
                ripe_idx = IDXW'(i);
            end
        end
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (valid_q[i] && x_q[i] == snap_x && y_q[i] == snap_y) begin
                dup_hit = 1'b1;
            end
            if (state_q == S_BLAST && valid_q[i] &&
                ((x_q[i] == ex_q && {1'b0, abs_diff(y_q[i], ey_q)} <= REACH) ||
                 (y_q[i] == ey_q && {1'b0, abs_diff(x_q[i], ex_q)} <= REACH))) begin
                in_cross[i] = 1'b1;
            end
            count = count + 3'(valid_q[i]);
        end
        accept   = place_edge & free_any & ~dup_hit;
        reject_d = place_edge & ~accept;
    end

    always_comb begin
        state_d     = state_q;
        blast_cnt_d = blast_cnt_q;
        ex_d        = ex_q;
        ey_d        = ey_q;
        launch_en   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ripe_any) begin
                    launch_en = 1'b1;
                    ex_d      = x_q[ripe_idx];
                    ey_d      = y_q[ripe_idx];
                    state_d   = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                blast_cnt_d = 8'(BLAST_TICKS);
                state_d     = S_BLAST;
            end
            S_BLAST: begin
                if (tick) begin
                    blast_cnt_d = blast_cnt_q - 8'd1;
                    if (blast_cnt_q <= 8'd1) begin
                        blast_cnt_d = 8'd0;
                        state_d     = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A newly placed bomb always lands in an empty slot, so it never collides with launch/chain updates.
    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            fuse_d[i] = fuse_q[i];
            x_d[i]    = x_q[i];
            y_d[i]    = y_q[i];
            if (valid_q[i]) begin
                if (in_cross[i]) begin
                    fuse_d[i] = 8'd0;
                end else if (tick && fuse_q[i] != 8'd0) begin
                    fuse_d[i] = fuse_q[i] - 8'd1;
                end
            end
            if (launch_en && ripe_idx == IDXW'(i)) begin
                valid_d[i] = 1'b0;
            end
            if (accept && free_idx == IDXW'(i)) begin
                valid_d[i] = 1'b1;
                fuse_d[i]  = 8'(FUSE_TICKS);
                x_d[i]     = snap_x;
                y_d[i]     = snap_y;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            place_q     <= 1'b0;
            reject_q    <= 1'b0;
            valid_q     <= '0;
            blast_cnt_q <= 8'd0;
            ex_q        <= 10'd0;
            ey_q        <= 10'd0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                fuse_q[i] <= 8'd0;
                x_q[i]    <= 10'd0;
                y_q[i]    <= 10'd0;
            end
        end else begin
            state_q     <= state_d;
            place_q     <= place;
            reject_q    <= reject_d;
            valid_q     <= valid_d;
            blast_cnt_q <= blast_cnt_d;
            ex_q        <= ex_d;
            ey_q        <= ey_d;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                fuse_q[i] <= fuse_d[i];
                x_q[i]    <= x_d[i];
                y_q[i]    <= y_d[i];
            end
        end
    end

    assign explosion_write_enable = (state_q == S_LAUNCH);
    assign blast_active           = (state_q == S_BLAST);
    assign exploding_bomb_x       = ex_q;
    assign exploding_bomb_y       = ey_q;
    assign slot_valid             = valid_q;
    assign active_count           = count;
    assign place_reject           = reject_q;
    assign fsm_state              = state_q;

endmodule
